// File: rtl/chroma_key_compositor.sv
// ============================================================================
// Module      : chroma_key_compositor
// Description : Green-screen mixer. Replaces keyed foreground pixels with the
//               matching background pixel and marks the last pixel of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chroma_key_compositor #(
    parameter int         C_FRAME_PIXELS   = 307200,
    parameter int         C_CNT_WIDTH      = 20,
    parameter logic [7:0] C_GMIN_DEFAULT   = 8'h60,
    parameter logic [7:0] C_MARGIN_DEFAULT = 8'h20
) (
    input  logic                   FSL_Clk,
    input  logic                   FSL_Rst,
    input  logic [0:31]            FSL_S_Data,
    input  logic                   FSL_S_Control,
    input  logic                   FSL_S_Exists,
    output logic                   FSL_S_Read,
    input  logic [0:31]            BG_Data,
    input  logic                   BG_Valid,
    output logic                   BG_Ready,
    output logic [0:31]            FSL_M_Data,
    output logic                   FSL_M_Control,
    output logic                   FSL_M_Write,
    input  logic                   FSL_M_Full,
    output logic [C_CNT_WIDTH-1:0] KEYED_COUNT,
    output logic                   FRAME_DONE
);

    localparam logic [C_CNT_WIDTH-1:0] c_last_pixel = C_CNT_WIDTH'(C_FRAME_PIXELS - 1);
    localparam logic [3:0]             c_sel_gmin   = 4'd0;
    localparam logic [3:0]             c_sel_margin = 4'd1;
    localparam logic [3:0]             c_sel_resync = 4'd2;

    logic [7:0]             r_gmin;
    logic [7:0]             r_margin;
    logic                   r_s1_valid;
    logic [0:31]            r_s1_fg;
    logic [0:31]            r_s1_bg;
    logic [7:0]             r_s1_gmin;
    logic [7:0]             r_s1_margin;
    logic                   r_s2_valid;
    logic [0:31]            r_s2_data;
    logic                   r_s2_ctrl;
    logic [C_CNT_WIDTH-1:0] r_pix_cnt;
    logic [C_CNT_WIDTH-1:0] r_keyed_acc;
    logic [C_CNT_WIDTH-1:0] r_keyed_count;
    logic                   r_frame_done;

    logic                   w_en;
    logic                   w_pix_acc;
    logic                   w_cfg_acc;
    logic [3:0]             w_cfg_sel;
    logic [7:0]             w_cfg_val;
    logic                   w_resync;
    logic [7:0]             w_r;
    logic [7:0]             w_g;
    logic [7:0]             w_b;
    logic [8:0]             w_r_lim;
    logic [8:0]             w_b_lim;
    logic                   w_keyed;
    logic                   w_frame_end;

    // Reset also blocks pops so nothing is consumed in the reset cycle.
    assign w_en      = !FSL_Rst && !(r_s2_valid && FSL_M_Full);
    assign w_pix_acc = w_en && FSL_S_Exists && !FSL_S_Control && BG_Valid;
    assign w_cfg_acc = w_en && FSL_S_Exists && FSL_S_Control;

    assign FSL_S_Read = w_en && FSL_S_Exists && (FSL_S_Control || BG_Valid);
    assign BG_Ready   = w_pix_acc;

    assign w_cfg_sel = FSL_S_Data[0:3];
    assign w_cfg_val = FSL_S_Data[24:31];
    assign w_resync  = w_cfg_acc && (w_cfg_sel == c_sel_resync);

    // Thresholds travel with the pixel so later config words never affect it.
    assign w_r     = r_s1_fg[8:15];
    assign w_g     = r_s1_fg[16:23];
    assign w_b     = r_s1_fg[24:31];
    assign w_r_lim = {1'b0, w_r} + {1'b0, r_s1_margin};
    assign w_b_lim = {1'b0, w_b} + {1'b0, r_s1_margin};
    assign w_keyed = (w_g >= r_s1_gmin) && ({1'b0, w_g} > w_r_lim) && ({1'b0, w_g} > w_b_lim);

    assign w_frame_end = (r_pix_cnt == c_last_pixel);

    always_ff @(posedge FSL_Clk) begin
        if (FSL_Rst) begin
            r_gmin        <= C_GMIN_DEFAULT;
            r_margin      <= C_MARGIN_DEFAULT;
            r_s1_valid    <= 1'b0;
            r_s1_fg       <= '0;
            r_s1_bg       <= '0;
            r_s1_gmin     <= '0;
            r_s1_margin   <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_data     <= '0;
            r_s2_ctrl     <= 1'b0;
            r_pix_cnt     <= '0;
            r_keyed_acc   <= '0;
            r_keyed_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_cfg_acc) begin
                case (w_cfg_sel)
                    c_sel_gmin:   r_gmin   <= w_cfg_val;
                    c_sel_margin: r_margin <= w_cfg_val;
                    default:      ;
                endcase
            end

            if (w_en) begin
                r_s1_valid <= w_pix_acc;
                if (w_pix_acc) begin
                    r_s1_fg     <= FSL_S_Data;
                    r_s1_bg     <= BG_Data;
                    r_s1_gmin   <= r_gmin;
                    r_s1_margin <= r_margin;
                end

                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_keyed ? r_s1_bg : r_s1_fg;
                    r_s2_ctrl <= w_frame_end;
                    if (w_frame_end) begin
                        r_pix_cnt     <= '0;
                        r_keyed_count <= r_keyed_acc + C_CNT_WIDTH'(w_keyed);
                        r_keyed_acc   <= '0;
                        r_frame_done  <= 1'b1;
                    end else begin
                        r_pix_cnt   <= r_pix_cnt + 1'b1;
                        r_keyed_acc <= r_keyed_acc + C_CNT_WIDTH'(w_keyed);
                    end
                end
            end

            // Later assignment wins: a coincident frame end is retired first.
            if (w_resync) begin
                r_pix_cnt   <= '0;
                r_keyed_acc <= '0;
            end
        end
    end

    assign FSL_M_Data    = r_s2_data;
    assign FSL_M_Control = r_s2_ctrl;
    assign FSL_M_Write   = r_s2_valid;
    assign KEYED_COUNT   = r_keyed_count;
    assign FRAME_DONE    = r_frame_done;

endmodule

`default_nettype wire
